// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the mesh NoC packet format: header field placement,
// the header builder used by transmitters (and the decode side of routers and
// receivers), and the transmitter FSM state type.
//
// Header layout (for a FLIT_WIDTH-bit flit, DEST_WIDTH-bit IDs):
//   [flit_w-1            -: dest_w] destination ID
//   [flit_w-dest_w-1     -: dest_w] source ID
//   [len_w-1 : LEN_LSB]             payload length
//   all other bits zero
// -----------------------------------------------------------------------------
package noc_pkg;

    // Length field always starts at bit 0 of the header.
    localparam int LEN_LSB = 0;

    // Transmitter FSM states.
    typedef enum logic [0:0] {
        TX_IDLE    = 1'b0,
        TX_PAYLOAD = 1'b1
    } tx_state_t;

    // MSB of the destination field for a given flit width.
    function automatic int noc_dest_msb(input int flit_w);
        return flit_w - 1;
    endfunction

    // MSB of the source field for a given flit / ID width.
    function automatic int noc_src_msb(input int flit_w, input int dest_w);
        return flit_w - dest_w - 1;
    endfunction

    // Build a header flit. The result is 64 bits wide so one function serves
    // every flit width up to 64; callers truncate to their FLIT_WIDTH.
    // Width arguments are elaboration constants, so the shifts are static.
    function automatic logic [63:0] noc_make_header(
        input logic [63:0] dest,
        input logic [63:0] src,
        input logic [63:0] len,
        input int          flit_w,
        input int          dest_w,
        input int          len_w
    );
        logic [63:0] id_mask;
        logic [63:0] len_mask;
        logic [63:0] hdr;
        id_mask  = (64'd1 << dest_w) - 64'd1;
        len_mask = (64'd1 << len_w) - 64'd1;
        hdr = ((dest & id_mask) << (noc_dest_msb(flit_w) - dest_w + 1))
            | ((src  & id_mask) << (noc_src_msb(flit_w, dest_w) - dest_w + 1))
            | ((len  & len_mask) << LEN_LSB);
        return hdr;
    endfunction

endpackage

// File: rtl/noc_packet_tx.sv
// -----------------------------------------------------------------------------
// noc_packet_tx
// Tile-side packet transmitter into one local NoC input channel. Takes a
// command (destination, payload length) plus a stream of payload words and
// emits one header flit followed by the payload flits, marking the last flit.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake; cmd_dest, cmd_len qualify it
//   data_valid/data_ready     payload word handshake; data carries the word
//   out_flit/out_last/
//   out_valid/out_ready       flit stream toward the NoC (registered)
//   err_len                   one-cycle pulse when a command with an illegal
//                             length is consumed and dropped
//   tx_count                  completed-packet counter, wraps at 16 bits
// -----------------------------------------------------------------------------
module noc_packet_tx
    import noc_pkg::*;
#(
    parameter int  FLIT_WIDTH = 32,
    parameter int  DEST_WIDTH = 5,
    parameter int  SRC_ID     = 0,
    parameter int  MAX_LEN    = 16,
    localparam int LEN_WIDTH  = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DEST_WIDTH-1:0] cmd_dest,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [FLIT_WIDTH-1:0] data,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err_len,
    output logic [15:0]           tx_count
);

    tx_state_t             state_q,     state_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic [FLIT_WIDTH-1:0] out_flit_q,  out_flit_d;
    logic                  out_last_q,  out_last_d;
    logic                  out_valid_q, out_valid_d;
    logic                  err_len_q,   err_len_d;
    logic [15:0]           tx_count_q,  tx_count_d;

    logic                  free_s;
    logic                  len_ok_s;
    logic                  cmd_ready_s;
    logic                  data_ready_s;
    logic [FLIT_WIDTH-1:0] header_s;

    // The output register may take a new flit when empty or being drained now.
    assign free_s   = !out_valid_q || out_ready;
    assign len_ok_s = (cmd_len <= LEN_WIDTH'(MAX_LEN));
    assign header_s = FLIT_WIDTH'(noc_make_header(64'(cmd_dest), 64'(SRC_ID),
                                                  64'(cmd_len), FLIT_WIDTH,
                                                  DEST_WIDTH, LEN_WIDTH));

    // Next-state logic for the FSM, output register, error pulse and counter.
    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        out_flit_d   = out_flit_q;
        out_last_d   = out_last_q;
        err_len_d    = 1'b0;
        cmd_ready_s  = 1'b0;
        data_ready_s = 1'b0;

        // A flit handshaking this cycle empties the register unless reloaded.
        if (free_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        case (state_q)
            TX_IDLE: begin
                // Held low while reset is asserted so nothing upstream fires.
                cmd_ready_s = free_s & rst;
                if (cmd_valid && cmd_ready_s) begin
                    if (len_ok_s) begin
                        out_flit_d  = header_s;
                        out_last_d  = (cmd_len == LEN_WIDTH'(0));
                        out_valid_d = 1'b1;
                        remaining_d = cmd_len;
                        if (cmd_len != LEN_WIDTH'(0)) begin
                            state_d = TX_PAYLOAD;
                        end else begin
                            state_d = TX_IDLE;
                        end
                    end else begin
                        // Illegal length: consume the command, emit nothing.
                        err_len_d = 1'b1;
                    end
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_PAYLOAD: begin
                data_ready_s = free_s;
                if (data_valid && data_ready_s) begin
                    out_flit_d  = data;
                    out_last_d  = (remaining_q == LEN_WIDTH'(1));
                    out_valid_d = 1'b1;
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d = TX_IDLE;
                    end else begin
                        state_d = TX_PAYLOAD;
                    end
                end else begin
                    state_d = TX_PAYLOAD;
                end
            end
            default: begin
                state_d     = TX_IDLE;
                remaining_d = '0;
            end
        endcase

        if (out_valid_q && out_ready && out_last_q) begin
            tx_count_d = tx_count_q + 16'd1;
        end else begin
            tx_count_d = tx_count_q;
        end
    end

    // State, output register and counter; reset abandons any partial packet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= TX_IDLE;
            remaining_q <= '0;
            out_flit_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_len_q   <= 1'b0;
            tx_count_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_flit_q  <= out_flit_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            err_len_q   <= err_len_d;
            tx_count_q  <= tx_count_d;
        end
    end

    assign cmd_ready  = cmd_ready_s;
    assign data_ready = data_ready_s;
    assign out_flit   = out_flit_q;
    assign out_last   = out_last_q;
    assign out_valid  = out_valid_q;
    assign err_len    = err_len_q;
    assign tx_count   = tx_count_q;

endmodule

// File: tb/tb_noc_packet_tx.sv
// Self-checking bench for noc_packet_tx: directed scenarios plus randomized
// packets, checked against a flit-list reference built from the packet format.
module tb_noc_packet_tx;

    localparam int FW  = 32;
    localparam int DW  = 5;
    localparam int SRC = 0;
    localparam int ML  = 16;
    localparam int LW  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [DW-1:0] cmd_dest = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic [FW-1:0] data = '0;
    logic [FW-1:0] out_flit;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          err_len;
    logic [15:0]   tx_count;

    noc_packet_tx #(.FLIT_WIDTH(FW), .DEST_WIDTH(DW), .SRC_ID(SRC), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest), .cmd_len(cmd_len),
        .data_valid(data_valid), .data_ready(data_ready), .data(data),
        .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .err_len(err_len), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [FW-1:0] flit; logic last; int stamp; } obs_t;
    obs_t        got_q[$];
    logic [FW:0] exp_q[$];     // {last, flit}
    int          n_vec = 0;
    int          n_fail = 0;
    int          err_cnt = 0;
    int          exp_count = 0;
    int          rdy_mode = 0;  // 0: always ready, 1: 1,0,0 pattern, 2: random
    int          pat_idx = 0;
    int          hs_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference header: dest at the top, source below it, length at bit 0.
    function automatic logic [FW-1:0] ref_hdr(input int d, input int l);
        return (32'(d) << (FW - DW)) | (32'(SRC) << (FW - 2 * DW)) | 32'(l);
    endfunction

    // Monitor: collect handshaked flits, check held flits stay stable, count err pulses.
    logic          held = 1'b0;
    logic [FW-1:0] held_flit;
    logic          held_last;
    always @(negedge clk) begin
        if (!rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_flit",  64'(out_flit),  64'(held_flit));
                chk("hold_last",  64'(out_last),  64'(held_last));
            end
            if (out_valid && out_ready) got_q.push_back('{out_flit, out_last, cyc});
            held      = out_valid && !out_ready;
            held_flit = out_flit;
            held_last = out_last;
            if (err_len === 1'b1) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = (pat_idx % 3 == 0); pat_idx++; end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
    endtask

    task automatic send_cmd(input int d, input int l);
        int n = 0;
        cmd_dest  = DW'(d);
        cmd_len   = LW'(l);
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 1000) begin tick(); n++; end
        if (n >= 1000) begin
            n_fail++;
            $error("FAIL cmd_timeout: observed no cmd_ready expected handshake");
        end
        hs_cyc = cyc;
        tick();
        if (l <= ML) begin
            exp_q.push_back({(l == 0), ref_hdr(d, l)});
            if (l == 0) exp_count++;
        end
    endtask

    task automatic send_data(input logic [FW-1:0] w, input logic is_last);
        int n = 0;
        chk("cmd_ready_in_payload", 64'(cmd_ready), 64'd0);
        data       = w;
        data_valid = 1'b1;
        while (data_ready !== 1'b1 && n < 1000) begin tick(); n++; end
        if (n >= 1000) begin
            n_fail++;
            $error("FAIL data_timeout: observed no data_ready expected handshake");
        end
        tick();
        data_valid = 1'b0;
        exp_q.push_back({is_last, w});
        if (is_last) exp_count++;
    endtask

    task automatic send_pkt(input int d, input int l);
        send_cmd(d, l);
        cmd_valid = 1'b0;
        for (int i = 0; i < l; i++) send_data(FW'($urandom), (i == l - 1));
    endtask

    task automatic wait_got();
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 2000) begin tick(); n++; end
        tick();
        chk("flit_count", 64'(got_q.size()), 64'(exp_q.size()));
    endtask

    task automatic compare_all();
        obs_t        o;
        logic [FW:0] e;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            o = got_q.pop_front();
            e = exp_q.pop_front();
            chk("flit", 64'(o.flit), 64'(e[FW-1:0]));
            chk("last", 64'(o.last), 64'(e[FW]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(); tick();
        #1 rst = 1'b1;
        tick();
        got_q.delete();
        exp_q.delete();
        exp_count = 0;
    endtask

    initial begin
        int e0;
        int t0;
        obs_t o;

        // Reset values
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_out_flit",  64'(out_flit),  64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_data_ready",64'(data_ready),64'd0);
        chk("rst_err_len",   64'(err_len),   64'd0);
        chk("rst_tx_count",  64'(tx_count),  64'd0);
        do_reset();

        // Basic packet, dest 5, len 3, with latency and back-to-back timing
        rdy_mode = 0;
        send_cmd(5, 3);
        t0 = hs_cyc;
        cmd_valid = 1'b0;
        send_data(32'hA1, 1'b0);
        send_data(32'hA2, 1'b0);
        send_data(32'hA3, 1'b1);
        wait_got();
        if (got_q.size() >= 4) begin
            chk("hdr_const", 64'(got_q[0].flit), 64'h28000003);
            for (int i = 0; i < 4; i++)
                chk("basic_stamp", 64'(got_q[i].stamp), 64'(t0 + 1 + i));
        end
        compare_all();
        chk("tx_count_1", 64'(tx_count), 64'(exp_count));

        // Same packet with out_ready toggling; monitor checks holding
        rdy_mode = 1;
        pat_idx  = 0;
        send_cmd(5, 3);
        cmd_valid = 1'b0;
        send_data(32'hA1, 1'b0);
        send_data(32'hA2, 1'b0);
        send_data(32'hA3, 1'b1);
        wait_got();
        compare_all();
        chk("tx_count_2", 64'(tx_count), 64'(exp_count));

        // Three header-only packets back-to-back
        rdy_mode = 0;
        tick();
        send_cmd(1, 0);
        t0 = hs_cyc;
        send_cmd(2, 0);
        send_cmd(3, 0);
        cmd_valid = 1'b0;
        wait_got();
        if (got_q.size() >= 3)
            for (int i = 0; i < 3; i++)
                chk("hdr_only_stamp", 64'(got_q[i].stamp), 64'(t0 + 1 + i));
        compare_all();
        chk("tx_count_3", 64'(tx_count), 64'(exp_count));

        // Over-length command is dropped with a single err_len pulse
        e0 = err_cnt;
        send_cmd(7, ML + 1);
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        chk("err_pulses", 64'(err_cnt), 64'(e0 + 1));
        chk("err_no_flit", 64'(got_q.size()), 64'd0);
        chk("err_no_valid", 64'(out_valid), 64'd0);
        send_pkt(4, 2);
        wait_got();
        compare_all();
        chk("tx_count_err", 64'(tx_count), 64'(exp_count));

        // Data offered while idle must not be consumed
        data_valid = 1'b1;
        data = 32'hDEAD_BEEF;
        tick();
        chk("idle_data_ready", 64'(data_ready), 64'd0);
        tick();
        chk("idle_data_ready", 64'(data_ready), 64'd0);
        data_valid = 1'b0;

        // Randomized packets, random back-pressure, occasional illegal lengths
        rdy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            int d;
            int l;
            d = int'($urandom_range(0, 31));
            l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(ML + 1, 31))
                                            : int'($urandom_range(0, ML));
            if (l > ML) begin
                e0 = err_cnt;
                send_cmd(d, l);
                cmd_valid = 1'b0;
                tick();
                chk("rand_err", 64'(err_cnt), 64'(e0 + 1));
            end else begin
                send_pkt(d, l);
            end
        end
        wait_got();
        compare_all();
        tick();
        chk("tx_count_rand", 64'(tx_count), 64'(exp_count & 32'hFFFF));

        // Reset in the middle of a 4-flit packet
        rdy_mode = 0;
        send_cmd(9, 4);
        cmd_valid = 1'b0;
        send_data(32'h11, 1'b0);
        send_data(32'h22, 1'b0);
        data_valid = 1'b1;
        data = 32'h33;
        #2 rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("midrst_data_ready",64'(data_ready),64'd0);
        chk("midrst_tx_count",  64'(tx_count),  64'd0);
        tick(); tick();
        #1 rst = 1'b1;
        got_q.delete();
        exp_q.delete();
        exp_count = 0;
        tick();
        chk("postrst_idle_data_ready", 64'(data_ready), 64'd0);
        chk("postrst_cmd_ready",       64'(cmd_ready),  64'd1);
        chk("postrst_out_valid",       64'(out_valid),  64'd0);
        data_valid = 1'b0;
        send_pkt(12, 1);
        wait_got();
        compare_all();
        chk("postrst_tx_count", 64'(tx_count), 64'(exp_count));

        // Counter wrap: 65535 header-only packets, then one more
        do_reset();
        for (int i = 0; i < 65535; i++) send_cmd(i % 32, 0);
        cmd_valid = 1'b0;
        wait_got();
        compare_all();
        chk("tx_count_ffff", 64'(tx_count), 64'hFFFF);
        send_cmd(30, 0);
        cmd_valid = 1'b0;
        wait_got();
        compare_all();
        chk("tx_count_wrap", 64'(tx_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
